// File: rtl/ifetch_unit.sv
// ifetch_unit: PC holder issuing one imem word read per cycle into a 2-entry decode buffer.
// Define IFETCH_STATS_EN to add saturating fetch/stall counters.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 4096,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_write_en,
    output logic [31:0] imem_write_data,
    input  logic [31:0] imem_read_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_fault
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0] stat_fetch_count,
    output logic [31:0] stat_stall_count
`endif
);
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic {RUN, HALT} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } entry_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q, tag_pc_q;
    logic        inflight_q, tag_fault_q;
    logic [1:0]  count_q;
    entry_t      head_q, second_q;

    logic   issue, push, pop, bad_pc;
    entry_t resp;

    assign imem_addr       = fetch_pc_q;
    assign imem_write_en   = 1'b0;
    assign imem_write_data = 32'h0;
    assign inst_valid      = count_q != 2'd0;
    assign inst_pc         = head_q.pc;
    assign inst_data       = head_q.data;
    assign inst_fault      = head_q.fault;

    always_comb begin
        bad_pc = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q > LAST_PC);
        // Credit counts pre-edge occupancy only; a same-cycle pop does not free a slot.
        issue  = (state_q == RUN) && !redirect_valid &&
                 (({1'b0, count_q} + {2'b00, inflight_q}) < 3'(BUF_DEPTH));
        push   = inflight_q && !redirect_valid;
        pop    = inst_valid && inst_ready;
        resp   = '{pc: tag_pc_q, data: tag_fault_q ? 32'hFFFF_FFFF : imem_read_data, fault: tag_fault_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fetch_pc_q  <= RESET_PC;
            tag_pc_q    <= 32'h0;
            tag_fault_q <= 1'b0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            head_q      <= '0;
            second_q    <= '0;
        end else if (redirect_valid) begin
            state_q    <= RUN;
            fetch_pc_q <= redirect_pc;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                tag_pc_q    <= fetch_pc_q;
                tag_fault_q <= bad_pc;
                fetch_pc_q  <= fetch_pc_q + 32'd4;
                if (bad_pc) state_q <= HALT;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
            // Head is kept in a register so outputs hold their last value once drained.
            if (pop) begin
                if (count_q == 2'd2) head_q <= second_q;
                else if (push) head_q <= resp;
            end else if (push) begin
                if (count_q == 2'd0) head_q <= resp;
                else second_q <= resp;
            end
        end
    end

`ifdef IFETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetch_count <= 32'h0;
            stat_stall_count <= 32'h0;
        end else begin
            if (pop && stat_fetch_count != 32'hFFFF_FFFF) stat_fetch_count <= stat_fetch_count + 32'd1;
            if (inst_valid && !inst_ready && stat_stall_count != 32'hFFFF_FFFF)
                stat_stall_count <= stat_stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized and directed stimulus against a queue-based fetch model.
module tb_ifetch_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] imem_addr, imem_write_data, imem_read_data = 32'h0;
    logic        imem_write_en;
    logic        redirect_valid = 1'b0, inst_ready = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid, inst_fault;
    logic [31:0] inst_data, inst_pc;
`ifdef IFETCH_STATS_EN
    logic [31:0] stat_fetch_count, stat_stall_count;
`endif

    ifetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_write_en(imem_write_en),
        .imem_write_data(imem_write_data), .imem_read_data(imem_read_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .inst_fault(inst_fault)
`ifdef IFETCH_STATS_EN
        , .stat_fetch_count(stat_fetch_count), .stat_stall_count(stat_stall_count)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return mem[a[11:2]];
    endfunction

    // Synchronous 1-cycle memory; misaligned/out-of-range reads return real words on purpose.
    always @(posedge clk) imem_read_data <= memword(imem_addr);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        f;
    } ent_t;

    ent_t        q[$];
    ent_t        last;
    bit          pend, halted;
    logic [31:0] ppc, fpc;
    int unsigned sfetch, sstall;
    int          n_chk = 0, n_pass = 0;

    function automatic bit bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > 32'd4092);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        if (q.size() > 0) last = q[0];
        chk("valid", 32'(inst_valid), 32'(q.size() > 0));
        chk("imem_addr", imem_addr, fpc);
        chk("inst_pc", inst_pc, last.pc);
        chk("inst_data", inst_data, last.data);
        chk("inst_fault", 32'(inst_fault), 32'(last.f));
        chk("write_en", 32'(imem_write_en), 32'h0);
        chk("write_data", imem_write_data, 32'h0);
`ifdef IFETCH_STATS_EN
        chk("stat_fetch", stat_fetch_count, sfetch);
        chk("stat_stall", stat_stall_count, sstall);
`endif
    endtask

    // Called and returns at a negedge; one clock of stimulus plus model update.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
        ent_t e;
        bit   issue;
        check_outputs();
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        @(posedge clk);
        if (q.size() > 0) begin
            if (rdy) sfetch++;
            else sstall++;
        end
        if (rv) begin
            q.delete();
            pend   = 0;
            fpc    = rpc;
            halted = 0;
        end else begin
            issue = !halted && (q.size() + int'(pend)) < 2;
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (pend) begin
                e.pc   = ppc;
                e.f    = bad(ppc);
                e.data = e.f ? 32'hFFFF_FFFF : memword(ppc);
                q.push_back(e);
            end
            pend = issue;
            if (issue) begin
                ppc    = fpc;
                halted = bad(fpc);
                fpc    = fpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        q.delete();
        last   = '0;
        pend   = 0;
        halted = 0;
        fpc    = 32'h0;
        sfetch = 0;
        sstall = 0;
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 32'h0, rdy);
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom % 4)
            0: return 32'($urandom_range(0, 1023)) << 2;
            1: return 32'd4096 - 32'd4 * 32'($urandom_range(1, 4));
            2: return 32'($urandom_range(0, 4095));
            default: return 32'hFFFF_FFF8;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h13;
        mem[1] = 32'h93;
        mem[2] = 32'h113;
        @(negedge clk);
        do_reset();
        run(8, 1);
        run(5, 0);
        run(6, 1);
        step(1, 32'h40, 1);
        run(6, 1);
        step(1, 32'd4084, 1);
        run(14, 1);
        step(1, 32'h0, 1);
        run(6, 1);
        step(1, 32'h6, 1);
        run(6, 1);
        step(1, 32'h0, 0);
        run(6, 0);
        do_reset();
        run(6, 1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 600 == 0) do_reset();
            else step($urandom % 16 == 0, rand_target(), $urandom % 4 != 0);
        end
        check_outputs();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
